seq_shift_rotate_unit: RTL
==========================

Name: seq_shift_rotate_unit

Overview:
- Multi-cycle shift/rotate execution unit for the datapath ALU path.
- Operates on the same operands the ALU receives: A comes from register Y, B comes from the bus.
- Performs SHR, SHRA, SHL, ROR and ROL by a variable amount, at most SHIFT_PER_CYCLE bit positions per clock.
- Uses a start/done handshake so the control sequencer can stall Zin until the result is valid.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of 2, at least 8.
- SHIFT_PER_CYCLE, 4, maximum bit positions shifted per clock; range 1..DATA_WIDTH.
- AMT_WIDTH, $clog2(DATA_WIDTH), number of low bits of b_in used as the shift amount.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled only when busy=0.
- opcode  in  5  operation select: 00101 SHR, 00110 SHRA, 00111 SHL, 01000 ROR, 01001 ROL.
- a_in  in  DATA_WIDTH  value to shift.
- b_in  in  DATA_WIDTH  shift amount source; only b_in[AMT_WIDTH-1:0] is used.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_WIDTH  shifted value; held until the next accepted start.
- illegal  out  1  high with done when the accepted opcode is not a shift/rotate.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from registers: busy=(state==SHIFT), done=(state==DONE).
- Reset (clear=0, asynchronous, any state): state=IDLE, result=0, busy=0, done=0, illegal=0, internal amount counter=0.
- Acceptance: start=1 at a rising edge (edge 0) while state is IDLE or DONE.
  - Latch opcode and amt=b_in[AMT_WIDTH-1:0].
  - Load the working register (drives result) with a_in.
- Next state after acceptance:
  - amt==0 or illegal opcode -> DONE. illegal=1 only when the opcode is illegal; result=a_in unchanged.
  - Otherwise -> SHIFT.
- SHIFT step, each edge: s=min(remaining, SHIFT_PER_CYCLE); apply the op by s bits; remaining -= s.
  - Transition to DONE on the edge where remaining reaches 0.
- Timing: done is high for exactly the cycle following edge E, where E=0 if amt==0 or illegal, else E=ceil(amt/SHIFT_PER_CYCLE).
- DONE -> IDLE on the next edge unless start=1, in which case the new request is accepted (back-to-back allowed).
- start while busy=1: ignored; no queuing. opcode, a_in and b_in changes during SHIFT have no effect.
- Operation semantics:
  - SHR: zero-fill from the MSB side.
  - SHRA: fill with the latched sign bit a_in[DATA_WIDTH-1].
  - SHL: zero-fill from the LSB side.
  - ROR/ROL: circular, no bits lost. An amount of DATA_WIDTH is not representable (amt < DATA_WIDTH always).
- Composition: the final result equals a single shift by amt, irrespective of SHIFT_PER_CYCLE.
- illegal clears on the next accepted start or on reset.
- Reset mid-operation aborts immediately; no done is produced for the aborted request.

Optional Feature:
- Macro SHIFT_FLAGS_EN.
- When defined, adds two outputs, both registered, valid while done=1 and held until the next accept:
  - zero_flag (1 bit): result==0.
  - carry_out (1 bit): last bit shifted out (SHR/SHRA: bit leaving the LSB; SHL: bit leaving the MSB; ROR/ROL: the bit that wrapped around).
  - Both are 0 when amt==0 or the opcode is illegal.
- When not defined: the ports do not exist and no flag logic is synthesized.

Test Plan:
- SHR, a_in=0xFFFA0000, b_in=4, SPC=4 -> done in cycle after edge 1, result=0x0FFFA000, busy high for 1 cycle.
- SHRA, a_in=0xFFFA0000, b_in=4 -> result=0xFFFFA000. Then SHL, a_in=0x00000011, b_in=31 -> E=8, busy high 8 cycles, result=0x80000000.
- ROR, a_in=0x00000011, b_in=4 -> 0x10000001. ROL, a_in=0x80000001, b_in=1 -> 0x00000003. With SHIFT_FLAGS_EN, the ROL case gives carry_out=1.
- b_in=0x00000020 (amt=0), a_in=0x12345678 -> done after edge 0, result=0x12345678, illegal=0. opcode=00001 -> done after edge 0, illegal=1, result=a_in.
- start pulsed again mid-SHIFT with different operands -> ignored, first result intact. start held high in DONE -> next op accepted with no IDLE cycle.
- clear driven low at edge 3 of a 31-bit SHL -> busy=0, done=0, result=0 asynchronously; no done pulse afterwards until a new start.

Source files
------------

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: SHR/SHRA/SHL/ROR/ROL, at most SHIFT_PER_CYCLE bits per clock.
// Define SHIFT_FLAGS_EN to add the registered zero_flag and carry_out outputs.
module seq_shift_rotate_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_PER_CYCLE = 4,
  parameter int AMT_WIDTH       = $clog2(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [4:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
`ifdef SHIFT_FLAGS_EN
  ,
  output logic                  zero_flag,
  output logic                  carry_out
`endif
);

  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;

  localparam int             CW    = AMT_WIDTH + 1;
  localparam logic [CW-1:0]  SPC_C = CW'(SHIFT_PER_CYCLE);
  localparam logic [CW-1:0]  DW_C  = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                 r_state, w_next_state;
  logic [4:0]             r_op;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [AMT_WIDTH-1:0]   r_rem;
  logic                   r_illegal;

  logic                   w_accept, w_legal;
  logic [AMT_WIDTH-1:0]   w_amt, w_rem_next, w_lo_idx, w_hi_idx;
  logic [CW-1:0]          w_rem_ext, w_step, w_comp;
  logic [DATA_WIDTH-1:0]  w_rot_r, w_rot_l, w_shifted;
  logic                   w_carry;
  logic                   w_unused;

  assign w_unused  = ^b_in[DATA_WIDTH-1:AMT_WIDTH];
  assign w_amt     = b_in[AMT_WIDTH-1:0];
  assign w_legal   = (opcode == OP_SHR) || (opcode == OP_SHRA) || (opcode == OP_SHL) ||
                     (opcode == OP_ROR) || (opcode == OP_ROL);
  assign w_accept  = start && (r_state != S_SHIFT);

  // Step is min(remaining, SHIFT_PER_CYCLE); it never exceeds DATA_WIDTH-1 since amt < DATA_WIDTH.
  assign w_rem_ext  = {1'b0, r_rem};
  assign w_step     = (w_rem_ext < SPC_C) ? w_rem_ext : SPC_C;
  assign w_comp     = DW_C - w_step;
  assign w_rem_next = r_rem - AMT_WIDTH'(w_step);
  assign w_lo_idx   = AMT_WIDTH'(w_step - 1'b1);
  assign w_hi_idx   = AMT_WIDTH'(w_comp);
  assign w_rot_r    = (r_work >> w_step) | (r_work << w_comp);
  assign w_rot_l    = (r_work << w_step) | (r_work >> w_comp);

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_shifted = r_work;
    w_carry   = 1'b0;
    case (r_op)
      OP_SHR: begin
        w_shifted = r_work >> w_step;
        w_carry   = r_work[w_lo_idx];
      end
      OP_SHRA: begin
        w_shifted = $unsigned($signed(r_work) >>> w_step);
        w_carry   = r_work[w_lo_idx];
      end
      OP_SHL: begin
        w_shifted = r_work << w_step;
        w_carry   = r_work[w_hi_idx];
      end
      OP_ROR: begin
        w_shifted = w_rot_r;
        w_carry   = w_rot_r[DATA_WIDTH-1];
      end
      OP_ROL: begin
        w_shifted = w_rot_l;
        w_carry   = w_rot_l[0];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)                  w_next_state = (w_legal && (w_amt != '0)) ? S_SHIFT : S_DONE;
        else if (r_state == S_DONE) w_next_state = S_IDLE;
      end
      S_SHIFT: if (w_rem_next == '0) w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_op      <= '0;
      r_work    <= '0;
      r_rem     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op      <= opcode;
      r_work    <= a_in;
      r_rem     <= w_legal ? w_amt : '0;
      r_illegal <= !w_legal;
    end else if (r_state == S_SHIFT) begin
      r_work    <= w_shifted;
      r_rem     <= w_rem_next;
    end
  end

  assign result  = r_work;
  assign illegal = r_illegal;

`ifdef SHIFT_FLAGS_EN
  logic r_zero, r_carry;

  // Carry follows each step so the last step leaves the final shifted-out bit.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_carry <= w_carry;
      r_zero  <= (w_rem_next == '0) && (w_shifted == '0);
    end
  end

  assign zero_flag = r_zero;
  assign carry_out = r_carry;
`endif

endmodule
